// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types, sizing helper and round-robin search for bram_arbiter.
package bram_arb_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_e;
   localparam int MAX_PORTS = 8;
   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } pick_t;
   function automatic int sel_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   // Walk downward so the last hit is the nearest set bit above last_owner.
   function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req, input logic [2:0] last_owner, input int n);
      pick_t p;
      p = '0;
      for (int i = n; i >= 1; i--)
         if (req[(int'(last_owner) + i) % n]) begin
            p.valid = 1'b1;
            p.idx   = 3'((int'(last_owner) + i) % n);
         end
      return p;
   endfunction
endpackage

// File: rtl/bram_rr_picker.sv
// bram_rr_picker: combinational round-robin winner search starting after last_owner.
module bram_rr_picker
   import bram_arb_pkg::*;
#(
   parameter  int NUM_PORTS = 2,
   localparam int SW        = sel_w(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [SW-1:0]        last_owner,
   output logic [SW-1:0]        win,
   output logic                 valid
);
   pick_t p;
   always_comb begin
      p     = rr_pick(MAX_PORTS'(req), 3'(last_owner), NUM_PORTS);
      win   = SW'(p.idx);
      valid = p.valid;
   end
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin owner of one shared BRAM port with read-latency drain.
// Optional hold watchdog enabled by BRAM_ARB_WATCHDOG_EN.
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter  int NUM_PORTS = 2,
   parameter  int RD_LAT    = 1,
   parameter  int MAX_HOLD  = 1024,
   localparam int SW        = sel_w(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req,
   input  logic [NUM_PORTS-1:0] rel,
   output logic [NUM_PORTS-1:0] gnt,
   output logic [SW-1:0]        sel,
   output logic                 access_en,
   output logic                 busy,
   output logic                 timeout
);
   localparam int CW = $clog2(RD_LAT + 1);
   arb_state_e           state, state_n;
   logic [NUM_PORTS-1:0] gnt_n;
   logic [SW-1:0]        sel_n, last_owner, last_n, win;
   logic [CW-1:0]        cnt, cnt_n;
   logic                 acc_n, valid, wd;

   bram_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick (
      .req       (req),
      .last_owner(last_owner),
      .win       (win),
      .valid     (valid)
   );

`ifdef BRAM_ARB_WATCHDOG_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold;
   assign wd = state == GRANT && hold == HW'(MAX_HOLD - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hold    <= '0;
         timeout <= 1'b0;
      end else begin
         hold    <= state == GRANT ? hold + HW'(1) : '0;
         timeout <= timeout | (wd & ~rel[sel]);
      end
`else
   assign wd      = 1'b0;
   assign timeout = MAX_HOLD < 0;
`endif

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      acc_n   = access_en;
      last_n  = last_owner;
      cnt_n   = cnt;
      case (state)
         IDLE:
            if (valid) begin
               state_n = GRANT;
               gnt_n   = NUM_PORTS'(1) << win;
               sel_n   = win;
               acc_n   = 1'b1;
               last_n  = win;
            end
         GRANT:
            if (rel[sel] || wd) begin
               state_n = DRAIN;
               gnt_n   = '0;
               acc_n   = 1'b0;
               cnt_n   = CW'(RD_LAT - 1);
            end
         DRAIN:
            if (cnt == '0) state_n = IDLE;
            else cnt_n = cnt - CW'(1);
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         gnt        <= '0;
         sel        <= '0;
         access_en  <= 1'b0;
         last_owner <= SW'(NUM_PORTS - 1);
         cnt        <= '0;
      end else begin
         state      <= state_n;
         gnt        <= gnt_n;
         sel        <= sel_n;
         access_en  <= acc_n;
         last_owner <= last_n;
         cnt        <= cnt_n;
      end

   assign busy = state != IDLE;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: randomized requesters checked against an owner/drain reference model.
module tb_bram_arbiter;
   localparam int N  = 3;
   localparam int RL = 2;
   localparam int MH = 8;
`ifdef BRAM_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic         clk = 1'b0, rst = 1'b1;
   logic [N-1:0] req = '0, rel = '0;
   logic [N-1:0] gnt;
   logic [1:0]   sel;
   logic         access_en, busy, timeout;

   bram_arbiter #(.NUM_PORTS(N), .RD_LAT(RL), .MAX_HOLD(MH)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .rel      (rel),
      .gnt      (gnt),
      .sel      (sel),
      .access_en(access_en),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   int m_owner, m_drain, m_last, m_sel, m_hold;
   bit m_to, stubborn, did_rst;
   int waits[N];
   logic [N-1:0] prev_gnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_owner = -1; m_drain = 0; m_last = N - 1; m_sel = 0; m_hold = 0; m_to = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      prev_gnt = '0;
      stubborn = 0;
   endtask

   // One clock edge of the reference: owner releases into a RL-cycle drain, idle picks next.
   task automatic m_step();
      if (m_owner >= 0) begin
         if (rel[m_owner]) begin
            m_owner = -1; m_drain = RL;
         end else if (WD && m_hold + 1 == MH) begin
            m_owner = -1; m_drain = RL; m_to = 1;
         end else m_hold++;
      end else if (m_drain > 0) m_drain--;
      else
         for (int i = 1; i <= N; i++) begin
            int k = (m_last + i) % N;
            if (req[k]) begin
               m_owner = k; m_sel = k; m_last = k; m_hold = 0;
               break;
            end
         end
   endtask

   task automatic check_outputs();
      logic [31:0] e_gnt;
      e_gnt = m_owner >= 0 ? 32'(1) << m_owner : 32'(0);
      check("gnt", 32'(gnt), e_gnt);
      check("sel", 32'(sel), 32'(m_sel));
      check("access_en", 32'(access_en), 32'(m_owner >= 0));
      check("busy", 32'(busy), 32'(m_owner >= 0 || m_drain > 0));
      check("timeout", 32'(timeout), 32'(m_to));
      check("onehot", 32'($onehot0(gnt)), 32'(1));
      check("acc_vs_gnt", 32'(access_en), 32'(|gnt));
   endtask

   // Fairness observed on the DUT grant stream: no requester sees more than N-1 foreign grants.
   task automatic track_fairness();
      if (gnt != '0 && gnt != prev_gnt) begin
         int k = $clog2(gnt);
         check("wait_bound", 32'(waits[k] <= N - 1), 32'(1));
         waits[k] = 0;
         for (int p = 0; p < N; p++)
            if (p != k && req[p]) waits[p]++;
         stubborn = WD && $urandom_range(0, 3) == 0;
      end
      prev_gnt = gnt;
   endtask

   initial begin
      m_reset();
      did_rst = 0;
      repeat (2) @(negedge clk);
      check_outputs();
      rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         m_step();
         @(negedge clk);
         check_outputs();
         track_fairness();
         if (cyc >= 1500 && !did_rst && m_owner >= 0) begin
            did_rst = 1;
            #1 rst = 1'b1;
            #1;
            check("rst_gnt", 32'(gnt), 32'(0));
            check("rst_acc", 32'(access_en), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_sel", 32'(sel), 32'(0));
            m_reset();
            req = '0; rel = '0;
            @(negedge clk);
            check_outputs();
            rst = 1'b0;
            req = N'(2);
            continue;
         end
         for (int p = 0; p < N; p++)
            if (m_owner == p) req[p] = 1'($urandom_range(0, 1));
            else if (!req[p]) req[p] = $urandom_range(0, 2) == 0;
         rel = N'($urandom) & N'($urandom);
         if (m_owner >= 0) rel[m_owner] = !stubborn && $urandom_range(0, 3) == 0;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
